// File: rtl/i2c_xfer_sched.sv
// Two-port round-robin I2C register-transaction scheduler. Expands one accepted
// request into the i2c_master command sequence and returns data plus a status code.
module i2c_xfer_sched #(
   parameter int unsigned MAX_LEN = 4,
   parameter int unsigned TIMEOUT = 2_000_000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  req_valid,
   output logic [1:0]  req_ready,
   input  logic [1:0]  req_rw,
   input  logic [13:0] req_dev,
   input  logic [15:0] req_reg,
   input  logic [5:0]  req_len,
   input  logic [63:0] req_wdata,
   output logic [1:0]  resp_valid,
   output logic [31:0] resp_rdata,
   output logic [1:0]  resp_err,
   output logic        m_start,
   output logic        m_stop,
   output logic        m_write,
   output logic        m_read,
   output logic        m_ack_in,
   output logic [7:0]  m_data_in,
   input  logic [7:0]  m_data_out,
   input  logic        m_done,
   input  logic        m_ack_err,
   output logic        busy
);

   typedef enum logic [2:0] {
      StIdle, StAddrW, StReg, StWdata, StAddrR, StRdata, StStop, StResp
   } state_e;

   state_e      state_q, state_d;
   logic        issued_q, issued_d;   // command levels for the current state are on the bus
   logic        port_q, port_d;
   logic        last_q, last_d;       // port served last; reset value favours port 0
   logic        rw_q, rw_d;
   logic [6:0]  dev_q, dev_d;
   logic [7:0]  reg_q, reg_d;
   logic [2:0]  len_q, len_d;
   logic [31:0] wdata_q, wdata_d;
   logic [2:0]  idx_q, idx_d;
   logic [31:0] wd_q, wd_d;
   logic [1:0]  req_ready_q, req_ready_d;
   logic [1:0]  resp_valid_q, resp_valid_d;
   logic [31:0] rdata_q, rdata_d;
   logic [1:0]  err_q, err_d;
   logic        busy_q, busy_d;
   logic        start_q, start_d, stop_q, stop_d, write_q, write_d;
   logic        read_q, read_d, ack_q, ack_d;
   logic [7:0]  data_q, data_d;

   logic        grant;
   logic [6:0]  dev_sel;
   logic [2:0]  len_raw;
   logic        is_last;
   logic [7:0]  wbyte;
   logic        fin;
   logic [1:0]  fin_err;

   // Arbitration, command sequencing, watchdog and completion
   always_comb begin
      state_d      = state_q;
      issued_d     = issued_q;
      port_d       = port_q;
      last_d       = last_q;
      rw_d         = rw_q;
      dev_d        = dev_q;
      reg_d        = reg_q;
      len_d        = len_q;
      wdata_d      = wdata_q;
      idx_d        = idx_q;
      wd_d         = wd_q;
      req_ready_d  = 2'b00;
      resp_valid_d = 2'b00;
      rdata_d      = rdata_q;
      err_d        = err_q;
      busy_d       = busy_q;
      start_d      = start_q;
      stop_d       = stop_q;
      write_d      = write_q;
      read_d       = read_q;
      ack_d        = ack_q;
      data_d       = data_q;
      grant        = 1'b0;
      dev_sel      = 7'd0;
      len_raw      = 3'd0;
      fin          = 1'b0;
      fin_err      = 2'd0;
      is_last      = (idx_q == len_q - 3'd1);
      wbyte        = 8'(wdata_q >> {idx_q, 3'b000});

      unique case (state_q)
         // RESP arbitrates exactly like IDLE so the next accept can follow resp_valid directly
         StIdle, StResp: begin
            state_d = StIdle;
            if (req_valid != 2'b00) begin
               grant       = (req_valid == 2'b11) ? ~last_q : req_valid[1];
               dev_sel     = grant ? req_dev[13:7] : req_dev[6:0];
               len_raw     = grant ? req_len[5:3] : req_len[2:0];
               port_d      = grant;
               rw_d        = grant ? req_rw[1] : req_rw[0];
               dev_d       = dev_sel;
               reg_d       = grant ? req_reg[15:8] : req_reg[7:0];
               wdata_d     = grant ? req_wdata[63:32] : req_wdata[31:0];
               len_d       = (len_raw == 3'd0 || 32'(len_raw) > MAX_LEN) ? 3'd1 : len_raw;
               idx_d       = 3'd0;
               rdata_d     = 32'd0;
               busy_d      = 1'b1;
               req_ready_d = grant ? 2'b10 : 2'b01;
               state_d     = StAddrW;
               issued_d    = 1'b1;
               wd_d        = 32'd0;
               start_d     = 1'b1;
               write_d     = 1'b1;
               data_d      = {dev_sel, 1'b0};
            end
         end
         default: begin
            if (!issued_q) begin
               // Gap cycle after a drop is over: drive this state's command levels
               issued_d = 1'b1;
               wd_d     = 32'd0;
               case (state_q)
                  StAddrW: begin start_d = 1'b1; write_d = 1'b1; data_d = {dev_q, 1'b0}; end
                  StReg:   begin write_d = 1'b1; data_d = reg_q; end
                  StWdata: begin write_d = 1'b1; data_d = wbyte; end
                  StAddrR: begin start_d = 1'b1; write_d = 1'b1; data_d = {dev_q, 1'b1}; end
                  StRdata: begin read_d = 1'b1; ack_d = is_last; end
                  StStop:  stop_d = 1'b1;
                  default: ;
               endcase
            end else if (m_done) begin
               {start_d, stop_d, write_d, read_d, ack_d} = 5'b0;
               data_d   = 8'd0;
               issued_d = 1'b0;
               wd_d     = 32'd0;
               // The master has already issued STOP after a NACK on any write-type byte
               if (m_ack_err && state_q inside {StAddrW, StReg, StWdata, StAddrR}) begin
                  fin     = 1'b1;
                  fin_err = 2'd1;
               end else begin
                  case (state_q)
                     StAddrW: state_d = StReg;
                     StReg: begin
                        state_d = rw_q ? StAddrR : StWdata;
                        idx_d   = 3'd0;
                     end
                     StWdata: begin
                        if (is_last) state_d = StStop;
                        else         idx_d   = idx_q + 3'd1;
                     end
                     StAddrR: begin
                        state_d = StRdata;
                        idx_d   = 3'd0;
                     end
                     StRdata: begin
                        rdata_d = rdata_q | (32'(m_data_out) << {idx_q, 3'b000});
                        if (is_last) state_d = StStop;
                        else         idx_d   = idx_q + 3'd1;
                     end
                     StStop:  fin = 1'b1;
                     default: ;
                  endcase
               end
            end else if (wd_q >= TIMEOUT) begin
               fin     = 1'b1;
               fin_err = 2'd2;
            end else begin
               wd_d = wd_q + 32'd1;
            end
         end
      endcase

      if (fin) begin
         {start_d, stop_d, write_d, read_d, ack_d} = 5'b0;
         data_d       = 8'd0;
         issued_d     = 1'b0;
         state_d      = StResp;
         resp_valid_d = port_q ? 2'b10 : 2'b01;
         err_d        = fin_err;
         busy_d       = 1'b0;
         last_d       = port_q;
      end
   end

   // State and output registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= StIdle;
         issued_q     <= 1'b0;
         port_q       <= 1'b0;
         last_q       <= 1'b1;
         rw_q         <= 1'b0;
         dev_q        <= 7'd0;
         reg_q        <= 8'd0;
         len_q        <= 3'd1;
         wdata_q      <= 32'd0;
         idx_q        <= 3'd0;
         wd_q         <= 32'd0;
         req_ready_q  <= 2'b00;
         resp_valid_q <= 2'b00;
         rdata_q      <= 32'd0;
         err_q        <= 2'd0;
         busy_q       <= 1'b0;
         start_q      <= 1'b0;
         stop_q       <= 1'b0;
         write_q      <= 1'b0;
         read_q       <= 1'b0;
         ack_q        <= 1'b0;
         data_q       <= 8'd0;
      end else begin
         state_q      <= state_d;
         issued_q     <= issued_d;
         port_q       <= port_d;
         last_q       <= last_d;
         rw_q         <= rw_d;
         dev_q        <= dev_d;
         reg_q        <= reg_d;
         len_q        <= len_d;
         wdata_q      <= wdata_d;
         idx_q        <= idx_d;
         wd_q         <= wd_d;
         req_ready_q  <= req_ready_d;
         resp_valid_q <= resp_valid_d;
         rdata_q      <= rdata_d;
         err_q        <= err_d;
         busy_q       <= busy_d;
         start_q      <= start_d;
         stop_q       <= stop_d;
         write_q      <= write_d;
         read_q       <= read_d;
         ack_q        <= ack_d;
         data_q       <= data_d;
      end
   end

   assign req_ready  = req_ready_q;
   assign resp_valid = resp_valid_q;
   assign resp_rdata = rdata_q;
   assign resp_err   = err_q;
   assign busy       = busy_q;
   assign m_start    = start_q;
   assign m_stop     = stop_q;
   assign m_write    = write_q;
   assign m_read     = read_q;
   assign m_ack_in   = ack_q;
   assign m_data_in  = data_q;

endmodule

// File: tb/tb_i2c_xfer_sched.sv
// Self-checking bench for i2c_xfer_sched: a responding master model logs every
// command; a transaction-level model predicts the byte sequence, data and status.
module tb_i2c_xfer_sched;

   logic        clk;
   logic        reset;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [1:0]  req_rw;
   logic [13:0] req_dev;
   logic [15:0] req_reg;
   logic [5:0]  req_len;
   logic [63:0] req_wdata;
   logic [1:0]  resp_valid;
   logic [31:0] resp_rdata;
   logic [1:0]  resp_err;
   logic        m_start, m_stop, m_write, m_read, m_ack_in;
   logic [7:0]  m_data_in;
   logic [7:0]  m_data_out;
   logic        m_done;
   logic        m_ack_err;
   logic        busy;

   int total;
   int bad;

   // Master model controls and command log: {start, stop, write, read, ack_in, data_in}
   logic [12:0] log_q[$];
   int          base;
   int          nack_at;
   bit          stall;
   logic [7:0]  rd_bytes[8];

   // Reference model results
   logic [12:0] exp_q[$];
   logic [1:0]  exp_err;
   logic [31:0] exp_rdata;
   logic [31:0] got_rdata;

   i2c_xfer_sched #(
      .MAX_LEN(4),
      .TIMEOUT(1000)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_rw    (req_rw),
      .req_dev   (req_dev),
      .req_reg   (req_reg),
      .req_len   (req_len),
      .req_wdata (req_wdata),
      .resp_valid(resp_valid),
      .resp_rdata(resp_rdata),
      .resp_err  (resp_err),
      .m_start   (m_start),
      .m_stop    (m_stop),
      .m_write   (m_write),
      .m_read    (m_read),
      .m_ack_in  (m_ack_in),
      .m_data_in (m_data_in),
      .m_data_out(m_data_out),
      .m_done    (m_done),
      .m_ack_err (m_ack_err),
      .busy      (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Master model: answers a raised command after 0..2 extra cycles with a one-cycle m_done
   initial begin : master_model
      int wait_n;
      int nr;
      wait_n     = -1;
      m_done     = 1'b0;
      m_ack_err  = 1'b0;
      m_data_out = 8'h00;
      forever begin
         @(negedge clk);
         m_done    = 1'b0;
         m_ack_err = 1'b0;
         if (!reset || stall) begin
            wait_n = -1;
         end else if (m_start || m_stop || m_write || m_read) begin
            if (wait_n < 0) wait_n = int'($urandom_range(0, 2));
            if (wait_n == 0) begin
               nr = 0;
               for (int i = base; i < log_q.size(); i++) if (log_q[i][9]) nr++;
               if (m_read) m_data_out = (nr < 8) ? rd_bytes[nr] : 8'h00;
               m_ack_err = (nack_at == log_q.size() - base);
               log_q.push_back({m_start, m_stop, m_write, m_read, m_ack_in, m_data_in});
               m_done = 1'b1;
               wait_n = -1;
            end else begin
               wait_n--;
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   // Expected bus sequence, status and read data for one request
   task automatic build_model(input bit rw, input logic [6:0] dev, input logic [7:0] rg,
                              input logic [2:0] ln, input logic [31:0] wd, input int nk);
      int n;
      exp_q.delete();
      n = (ln == 3'd0 || ln > 3'd4) ? 1 : int'(ln);
      exp_q.push_back({4'b1010, 1'b0, dev, 1'b0});
      exp_q.push_back({4'b0010, 1'b0, rg});
      if (!rw) begin
         for (int k = 0; k < n; k++) exp_q.push_back({4'b0010, 1'b0, wd[8*k +: 8]});
      end else begin
         exp_q.push_back({4'b1010, 1'b0, dev, 1'b1});
         for (int k = 0; k < n; k++) exp_q.push_back({4'b0001, (k == n - 1), 8'h00});
      end
      exp_q.push_back({4'b0100, 1'b0, 8'h00});
      exp_err   = 2'd0;
      exp_rdata = 32'd0;
      if (nk >= 0 && nk < exp_q.size() && exp_q[nk][10]) begin
         while (exp_q.size() > nk + 1) void'(exp_q.pop_back());
         exp_err = 2'd1;
      end else if (rw) begin
         for (int k = 0; k < n; k++) exp_rdata[8*k +: 8] = rd_bytes[k];
      end
   endtask

   task automatic apply_reset();
      reset     = 1'b0;
      req_valid = 2'b00;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
   endtask

   // One complete transaction on port p, checked against the model
   task automatic run_xfer(input int p, input bit rw, input logic [6:0] dev, input logic [7:0] rg,
                           input logic [2:0] ln, input logic [31:0] wd, input int nk);
      logic [1:0]  oh;
      logic [12:0] got, ex, mask;
      int          n;
      int          got_n;
      oh = (p == 1) ? 2'b10 : 2'b01;
      req_rw[p]            = rw;
      req_dev[7*p +: 7]    = dev;
      req_reg[8*p +: 8]    = rg;
      req_len[3*p +: 3]    = ln;
      req_wdata[32*p +: 32] = wd;
      build_model(rw, dev, rg, ln, wd, nk);
      nack_at = nk;
      base    = log_q.size();
      req_valid[p] = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (req_ready[p] !== 1'b1 && n < 50);
      total++;
      if (req_ready !== oh || busy !== 1'b1 || m_start !== 1'b1) begin
         bad++;
         $display("FAIL accept p%0d: req_ready=%b busy=%b m_start=%b, want %b/1/1",
                  p, req_ready, busy, m_start, oh);
      end
      req_valid[p] = 1'b0;
      n = 0;
      do begin @(negedge clk); n++; end while (resp_valid === 2'b00 && n < 3000);
      total++;
      if (resp_valid !== oh) begin
         bad++;
         $display("FAIL resp_valid p%0d: got %b want %b", p, resp_valid, oh);
      end
      total++;
      if (resp_err !== exp_err) begin
         bad++;
         $display("FAIL resp_err p%0d: got %0d want %0d", p, resp_err, exp_err);
      end
      total++;
      if (resp_rdata !== exp_rdata) begin
         bad++;
         $display("FAIL resp_rdata p%0d: got %h want %h", p, resp_rdata, exp_rdata);
      end
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL busy_at_resp p%0d: got %b want 0", p, busy);
      end
      got_rdata = resp_rdata;
      got_n = log_q.size() - base;
      total++;
      if (got_n != exp_q.size()) begin
         bad++;
         $display("FAIL cmd_count p%0d: got %0d want %0d", p, got_n, exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_n; i++) begin
         ex   = exp_q[i];
         got  = log_q[base + i];
         mask = {4'hF, ex[9], ex[10] ? 8'hFF : 8'h00};
         total++;
         if ((got & mask) !== (ex & mask)) begin
            bad++;
            $display("FAIL cmd[%0d] p%0d: got %h want %h (mask %h)", i, p, got, ex, mask);
         end
      end
      @(negedge clk);
      total++;
      if (resp_valid !== 2'b00 || {m_start, m_stop, m_write, m_read, m_ack_in} !== 5'b0) begin
         bad++;
         $display("FAIL after_resp p%0d: resp_valid=%b cmds=%b want 00/00000", p, resp_valid,
                  {m_start, m_stop, m_write, m_read, m_ack_in});
      end
   endtask

   task automatic test_reset();
      apply_reset();
      reset = 1'b0;
      @(negedge clk);
      total++;
      if (req_ready !== 2'b00 || resp_valid !== 2'b00 || busy !== 1'b0) begin
         bad++;
         $display("FAIL reset_hs: ready=%b resp_valid=%b busy=%b want 0", req_ready,
                  resp_valid, busy);
      end
      total++;
      if (resp_rdata !== 32'd0 || resp_err !== 2'd0) begin
         bad++;
         $display("FAIL reset_resp: rdata=%h err=%0d want 0", resp_rdata, resp_err);
      end
      total++;
      if ({m_start, m_stop, m_write, m_read, m_ack_in, m_data_in} !== 13'd0) begin
         bad++;
         $display("FAIL reset_master: got %h want 0",
                  {m_start, m_stop, m_write, m_read, m_ack_in, m_data_in});
      end
      reset = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_write();
      logic [7:0] b0, b2, b3;
      run_xfer(0, 1'b0, 7'h50, 8'h10, 3'd2, 32'h0000BEEF, -1);
      b0 = (log_q.size() > base)     ? log_q[base][7:0]     : 8'hxx;
      b2 = (log_q.size() > base + 2) ? log_q[base + 2][7:0] : 8'hxx;
      b3 = (log_q.size() > base + 3) ? log_q[base + 3][7:0] : 8'hxx;
      total++;
      if ({b0, b2, b3} !== 24'hA0EFBE) begin
         bad++;
         $display("FAIL write_bytes: got %h want A0EFBE", {b0, b2, b3});
      end
   endtask

   task automatic test_read();
      logic [7:0] ar;
      rd_bytes[0] = 8'h11;
      rd_bytes[1] = 8'h22;
      rd_bytes[2] = 8'h33;
      run_xfer(1, 1'b1, 7'h68, 8'h3B, 3'd3, 32'h0, -1);
      total++;
      if (got_rdata !== 32'h00332211) begin
         bad++;
         $display("FAIL read_data: got %h want 00332211", got_rdata);
      end
      ar = (log_q.size() > base + 2) ? log_q[base + 2][7:0] : 8'hxx;
      total++;
      if (ar !== 8'hD1) begin
         bad++;
         $display("FAIL read_addr: got %h want D1", ar);
      end
   endtask

   task automatic test_nack();
      run_xfer(0, 1'b0, 7'h50, 8'h10, 3'd2, 32'h0000BEEF, 0);
      run_xfer(1, 1'b0, 7'h22, 8'h01, 3'd4, 32'h44332211, 3);
      nack_at = -1;
   endtask

   task automatic test_arb();
      int order[$];
      int rorder[$];
      int want[3];
      int n;
      bit rearmed;
      want[0] = 0; want[1] = 1; want[2] = 0;
      nack_at = -1;
      apply_reset();
      req_rw    = 2'b00;
      req_len   = {3'd1, 3'd1};
      req_dev   = {7'h11, 7'h22};
      req_reg   = 16'h0102;
      req_wdata = {32'hAA, 32'hBB};
      req_valid = 2'b11;
      n = 0;
      rearmed = 1'b0;
      while (rorder.size() < 3 && n < 3000) begin
         @(negedge clk);
         n++;
         if (req_ready[0] === 1'b1) begin order.push_back(0); req_valid[0] = 1'b0; end
         if (req_ready[1] === 1'b1) begin order.push_back(1); req_valid[1] = 1'b0; end
         if (resp_valid[0] === 1'b1) begin
            rorder.push_back(0);
            if (!rearmed) begin req_valid[0] = 1'b1; rearmed = 1'b1; end
         end
         if (resp_valid[1] === 1'b1) rorder.push_back(1);
      end
      req_valid = 2'b00;
      total++;
      if (order.size() != 3 || rorder.size() != 3) begin
         bad++;
         $display("FAIL arb_count: grants=%0d resps=%0d want 3/3", order.size(), rorder.size());
      end
      for (int i = 0; i < 3; i++) begin
         total++;
         if ((i < order.size() ? order[i] : -1) != want[i] ||
             (i < rorder.size() ? rorder[i] : -1) != want[i]) begin
            bad++;
            $display("FAIL arb_order[%0d]: grant=%0d resp=%0d want %0d", i,
                     (i < order.size() ? order[i] : -1), (i < rorder.size() ? rorder[i] : -1),
                     want[i]);
         end
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_back_to_back();
      int nk;
      for (int t = 0; t < 40; t++) begin
         for (int k = 0; k < 8; k++) rd_bytes[k] = 8'($urandom);
         nk = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 8)) : -1;
         run_xfer(int'($urandom_range(0, 1)), 1'($urandom), 7'($urandom), 8'($urandom),
                  3'($urandom), $urandom, nk);
      end
      nack_at = -1;
   endtask

   task automatic test_timeout();
      int n;
      stall = 1'b1;
      req_rw[0]        = 1'b0;
      req_len[2:0]     = 3'd1;
      req_dev[6:0]     = 7'h3C;
      req_valid[0]     = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (req_ready[0] !== 1'b1 && n < 50);
      req_valid[0] = 1'b0;
      total++;
      if (m_start !== 1'b1) begin
         bad++;
         $display("FAIL to_start: got %b want 1", m_start);
      end
      n = 0;
      do begin @(negedge clk); n++; end while (resp_valid === 2'b00 && n < 1100);
      total++;
      if (n != 1001) begin
         bad++;
         $display("FAIL to_latency: got %0d want 1001", n);
      end
      total++;
      if (resp_valid !== 2'b01 || resp_err !== 2'd2 || busy !== 1'b0) begin
         bad++;
         $display("FAIL to_resp: valid=%b err=%0d busy=%b want 01/2/0", resp_valid, resp_err,
                  busy);
      end
      total++;
      if ({m_start, m_stop, m_write, m_read} !== 4'b0) begin
         bad++;
         $display("FAIL to_drop: got %b want 0000", {m_start, m_stop, m_write, m_read});
      end
      stall = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset_mid();
      int n;
      int seen;
      for (int k = 0; k < 8; k++) rd_bytes[k] = 8'($urandom);
      base         = log_q.size();
      req_rw[0]    = 1'b1;
      req_len[2:0] = 3'd4;
      req_dev[6:0] = 7'h68;
      req_valid[0] = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (req_ready[0] !== 1'b1 && n < 50);
      req_valid[0] = 1'b0;
      n = 0;
      do begin @(negedge clk); n++; end while (m_read !== 1'b1 && n < 500);
      total++;
      if (m_read !== 1'b1) begin
         bad++;
         $display("FAIL rst_reach_rdata: m_read=%b want 1", m_read);
      end
      reset = 1'b0;
      @(negedge clk);
      total++;
      if ({req_ready, resp_valid, resp_err, busy} !== 7'd0 || resp_rdata !== 32'd0) begin
         bad++;
         $display("FAIL rst_mid_outs: hs=%b rdata=%h want 0", {req_ready, resp_valid,
                  resp_err, busy}, resp_rdata);
      end
      total++;
      if ({m_start, m_stop, m_write, m_read, m_ack_in, m_data_in} !== 13'd0) begin
         bad++;
         $display("FAIL rst_mid_master: got %h want 0",
                  {m_start, m_stop, m_write, m_read, m_ack_in, m_data_in});
      end
      reset = 1'b1;
      seen = 0;
      repeat (30) begin
         @(negedge clk);
         if (resp_valid !== 2'b00) seen++;
      end
      total++;
      if (seen != 0) begin
         bad++;
         $display("FAIL rst_no_resp: got %0d pulses want 0", seen);
      end
   endtask

   initial begin
      total     = 0;
      bad       = 0;
      base      = 0;
      nack_at   = -1;
      stall     = 1'b0;
      reset     = 1'b0;
      req_valid = 2'b00;
      req_rw    = 2'b00;
      req_dev   = '0;
      req_reg   = '0;
      req_len   = '0;
      req_wdata = '0;
      for (int k = 0; k < 8; k++) rd_bytes[k] = 8'h00;
      test_reset();
      test_write();
      test_read();
      test_nack();
      test_arb();
      test_back_to_back();
      test_timeout();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/i2c_xfer_sched.md
# i2c_xfer_sched

Two-port I2C register-transaction scheduler placed in front of `i2c_master`. It arbitrates round-robin between two requesters, for example the sensor poller and the display/config block. It expands each accepted request into the master's byte-level command sequence: START+address, register byte, data bytes, repeated START, reads with ACK/NACK, and STOP. It returns read data plus a completion/error code to the requester that was granted.

## Interface
- `MAX_LEN`, 4: maximum data bytes per transaction; `req_len` range 1..MAX_LEN.
- `TIMEOUT`, 2_000_000: clk cycles allowed per master command before a timeout abort.
- `clk`  in  1  system clock.
- `reset`  in  1  reset, synchronous, active-low.
- `req_valid`  in  2  per-port request; held high until the matching `req_ready`.
- `req_ready`  out  2  one-cycle accept pulse to the granted port.
- `req_rw`  in  2  per port: 1=read, 0=write.
- `req_dev`  in  14  packed 7-bit device addresses; port p uses bits [7p+6:7p].
- `req_reg`  in  16  packed 8-bit register addresses.
- `req_len`  in  6  packed 3-bit byte counts.
- `req_wdata`  in  64  packed 32-bit write data; byte 0 in [7:0] is sent first.
- `resp_valid`  out  2  one-cycle completion pulse to the owning port.
- `resp_rdata`  out  32  read data; first byte read lands in [7:0]; unread bytes are 0.
- `resp_err`  out  2  0=OK, 1=NACK, 2=timeout; valid with `resp_valid`.
- `m_start, m_stop, m_write, m_read`  out  1 each  command levels to the master.
- `m_ack_in`  out  1  0=ACK, 1=NACK for the byte being read.
- `m_data_in`  out  8  byte for the master.
- `m_data_out`  in  8  byte read by the master.
- `m_done`  in  1  master completion pulse.
- `m_ack_err`  in  1  master NACK flag; sampled with `m_done`.
- `busy`  out  1  high from accept until `resp_valid`.

## Operation
- States: IDLE, ADDR_W, REG, WDATA, ADDR_R, RDATA, STOP, RESP.
- IDLE:
  - Select the requesting port. If both ports request, pick the port not served last. The pointer resets to favour port 0.
  - Pulse `req_ready[p]`, capture all fields of port p, and go to ADDR_W.
- ADDR_W: `m_start=1`, `m_write=1`, `m_data_in={dev,1'b0}`.
- REG: `m_write=1`, `m_data_in=reg`.
  - Write requests go to WDATA.
  - Read requests go to ADDR_R.
- WDATA: `m_write=1`, bytes 0..len-1 in order, then STOP.
- ADDR_R: `m_start=1`, `m_write=1`, `m_data_in={dev,1'b1}` (repeated START).
- RDATA: `m_read=1`, `len` bytes.
  - `m_ack_in=0` on every byte except the last, which uses `m_ack_in=1`.
  - Byte k is stored into `resp_rdata[8k+7:8k]` on `m_done`.
  - After the last byte, go to STOP.
- STOP: `m_stop=1` until `m_done`, then RESP with err=0.
- RESP: pulse `resp_valid[p]`, deassert `busy`, update the RR pointer to p, return to IDLE.
- Command handshake:
  - Exactly one command is driven at a time.
  - Levels are held until `m_done`, then all command outputs drop to 0 on the next edge.
  - The next state's levels are driven the edge after that.
- NACK: `m_done` with `m_ack_err=1` during any write-type state means the master has already generated STOP. Skip STOP, go to RESP with err=1; `resp_rdata` holds the bytes read so far.
- Timeout: the watchdog resets on every `m_done` and on each state entry. Reaching TIMEOUT drops all commands and goes to RESP with err=2.
- `req_len=0` or `>MAX_LEN` is clamped to 1.
- Requests on the non-granted port wait; their fields are ignored until accepted.

## Timing
- Reset values: `req_ready=0`, `resp_valid=0`, `resp_rdata=0`, `resp_err=0`, `busy=0`, all `m_*` outputs 0, `m_data_in=0`, RR pointer favours port 0.
- All outputs are registered.
- Accept: `req_ready` pulses 1 cycle after `req_valid` is sampled in IDLE.
- `m_start` rises on the same edge as that pulse.
- `resp_valid` pulses exactly 1 cycle, 1 cycle after the final `m_done` (or the timeout).
- The next accept can occur at the earliest 1 cycle after `resp_valid`.
- Requires at least 2 clk between consecutive master ticks, so that command drops are seen before the master's next tick.
- Reset asserted mid-transaction:
  - Returns to IDLE with outputs at their reset values.
  - No `resp_valid` is generated.
  - The master is reset by the same reset.

## Test plan
- Port 0 write, dev=0x50, reg=0x10, len=2, wdata=0x0000BEEF, slave ACKs all bytes -> bus bytes A0,10,EF,BE then STOP; `resp_valid[0]`, `resp_err=0`.
- Port 1 read, dev=0x68, reg=0x3B, len=3, slave returns 11,22,33 -> bus D0,3B, repeated START, D1, reads with ACK/ACK/NACK, STOP; `resp_rdata=0x00332211`.
- Address NACK on a port 0 write -> no further bytes sent; `resp_err=1`, `resp_valid[0]` only, `busy` falls.
- Both ports valid in the same cycle after reset -> port 0 served first, then port 1. Port 0 re-requests while port 1 is active -> port 0 waits; the sequence alternates 0,1,0.
- Slave holds SCL low (tick stopped) beyond TIMEOUT=1000 -> `resp_err=2` at cycle 1000+1, back to IDLE.
- `reset` pulled low during RDATA -> next cycle all outputs are 0 and `busy=0`, with no `resp_valid`.
